// File: rtl/sale_line_bank.sv
// sale_line_bank: bank of NUM_LINES display lines with append/indexed writes
// and a one-slot-per-cycle clear sweep. lines is a flat view of the slots.
module sale_line_bank #(
   parameter int unsigned NUM_LINES = 13,
   parameter int unsigned LINE_W    = 77
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic                        wr_mode,
   input  logic [3:0]                  wr_idx,
   input  logic [LINE_W-1:0]           wr_data,
   input  logic                        clr_req,
   output logic [NUM_LINES*LINE_W-1:0] lines,
   output logic [3:0]                  count,
   output logic                        full,
   output logic                        empty,
   output logic                        busy,
   output logic                        err
);

   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] MAX_CNT  = CW'(NUM_LINES);
   localparam logic [CW-1:0] LAST_IDX = CW'(NUM_LINES - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state, state_next;
   logic [LINE_W-1:0] slot [NUM_LINES];
   logic [CW-1:0]     ptr, ptr_next;
   logic [CW-1:0]     count_next;
   logic              err_next;
   logic              busy_next;
   logic              we;
   logic [CW-1:0]     we_idx;
   logic [LINE_W-1:0] we_data;
   logic              accept;

   // Handshake and count decodes are combinational so a write can land every cycle.
   assign wr_ready = (state == IDLE) && !clr_req;
   assign accept   = wr_valid && wr_ready;
   assign full     = (count == MAX_CNT);
   assign empty    = (count == '0);

   // Slots drive the flat output bus directly.
   for (genvar k = 0; k < int'(NUM_LINES); k++) begin : g_lines
      assign lines[k*LINE_W +: LINE_W] = slot[k];
   end

   // Control state, sweep pointer, count and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= '0;
         count <= '0;
         err   <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
         count <= count_next;
         err   <= err_next;
         busy  <= busy_next;
      end
   end

   // Slot storage; a single write port shared by writes and the clear sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(NUM_LINES); k++) slot[k] <= '0;
      end else if (we) begin
         for (int k = 0; k < int'(NUM_LINES); k++) begin
            if (we_idx == CW'(k)) slot[k] <= we_data;
         end
      end
   end

   // Next-state, write decode and reject detection.
   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      count_next = count;
      err_next   = 1'b0;
      we         = 1'b0;
      we_idx     = '0;
      we_data    = '0;
      unique case (state)
         IDLE: begin
            if (clr_req) begin
               state_next = CLEAR;
               ptr_next   = '0;
            end else if (accept) begin
               if (!wr_mode) begin
                  if (count < MAX_CNT) begin
                     we         = 1'b1;
                     we_idx     = count;
                     we_data    = wr_data;
                     count_next = count + CW'(1);
                  end else begin
                     err_next = 1'b1;
                  end
               end else begin
                  if (wr_idx < MAX_CNT) begin
                     we      = 1'b1;
                     we_idx  = wr_idx;
                     we_data = wr_data;
                     if (wr_idx >= count) count_next = wr_idx + CW'(1);
                  end else begin
                     err_next = 1'b1;
                  end
               end
            end
         end
         CLEAR: begin
            // clr_req is ignored here: the sweep always runs to completion.
            we       = 1'b1;
            we_idx   = ptr;
            ptr_next = ptr + CW'(1);
            if (ptr == LAST_IDX) begin
               state_next = IDLE;
               ptr_next   = '0;
               count_next = '0;
            end
         end
         default: state_next = IDLE;
      endcase
      busy_next = (state_next == CLEAR);
   end

endmodule

// File: tb/tb_sale_line_bank.sv
// Directed self-checking bench for sale_line_bank.
module tb_sale_line_bank;

   localparam int unsigned NL = 13;
   localparam int unsigned LW = 77;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             wr_valid;
   logic             wr_ready;
   logic             wr_mode;
   logic [3:0]       wr_idx;
   logic [LW-1:0]    wr_data;
   logic             clr_req;
   logic [NL*LW-1:0] lines;
   logic [3:0]       count;
   logic             full;
   logic             empty;
   logic             busy;
   logic             err;

   int checks = 0;
   int errors = 0;

   sale_line_bank #(.NUM_LINES(NL), .LINE_W(LW)) dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_mode(wr_mode), .wr_idx(wr_idx), .wr_data(wr_data), .clr_req(clr_req),
      .lines(lines), .count(count), .full(full), .empty(empty), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [LW-1:0] slot_of(input int k);
      return lines[k*LW +: LW];
   endfunction

   task automatic idle_inputs();
      wr_valid = 1'b0; wr_mode = 1'b0; wr_idx = '0; wr_data = '0; clr_req = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #3;
      checks++;
      if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || busy !== 1'b0 ||
          err !== 1'b0 || wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_flags: count=%0d empty=%b full=%b busy=%b err=%b rdy=%b, required 0 1 0 0 0 1",
                  count, empty, full, busy, err, wr_ready);
      end
      checks++;
      if (lines !== '0) begin
         errors++;
         $display("FAIL reset_lines: lines nonzero, required all zero");
      end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_append_full();
      logic [NL*LW-1:0] snap;
      int bad = 0;
      for (int k = 0; k < int'(NL); k++) begin
         wr_valid = 1'b1; wr_mode = 1'b0; wr_data = LW'(k + 1);
         step();
      end
      wr_valid = 1'b0;
      for (int k = 0; k < int'(NL); k++) if (slot_of(k) !== LW'(k + 1)) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL append_slots: %0d slots differ from k+1", bad);
      end
      checks++;
      if (count !== 4'd13 || full !== 1'b1 || empty !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL append_full: count=%0d full=%b empty=%b err=%b, required 13 1 0 0",
                  count, full, empty, err);
      end
      snap = lines;
      wr_valid = 1'b1; wr_data = LW'(99);
      step();
      wr_valid = 1'b0;
      checks++;
      if (err !== 1'b1 || count !== 4'd13 || lines !== snap) begin
         errors++;
         $display("FAIL append_overflow: err=%b count=%0d lines_same=%b, required 1 13 1",
                  err, count, lines === snap);
      end
      step();
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL overflow_err_width: err=%b, required 0", err);
      end
   endtask

   task automatic test_clear_with_write();
      int n;
      wr_valid = 1'b1; wr_mode = 1'b1; wr_idx = 4'd0; wr_data = LW'(16'hFFFF);
      clr_req = 1'b1;
      #1;
      checks++;
      if (wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL clr_ready: wr_ready=%b, required 0", wr_ready);
      end
      step();
      wr_valid = 1'b0; clr_req = 1'b0;
      n = busy ? 1 : 0;
      checks++;
      if (slot_of(0) !== LW'(1) || busy !== 1'b1 || count !== 4'd13) begin
         errors++;
         $display("FAIL clr_start: slot0=%0h busy=%b count=%0d, required 1 1 13",
                  slot_of(0), busy, count);
      end
      for (int c = 0; c < 20 && busy; c++) begin
         step();
         if (busy) n++;
         if (n == 6) begin
            checks++;
            if (count !== 4'd13 || slot_of(12) !== LW'(13)) begin
               errors++;
               $display("FAIL clr_midsweep: count=%0d slot12=%0h, required 13 d", count, slot_of(12));
            end
         end
      end
      checks++;
      if (n != 13) begin
         errors++;
         $display("FAIL clr_busy_len: busy cycles=%0d, required 13", n);
      end
      checks++;
      if (lines !== '0 || count !== 4'd0 || empty !== 1'b1 || wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL clr_done: lines_zero=%b count=%0d empty=%b rdy=%b, required 1 0 1 1",
                  lines === '0, count, empty, wr_ready);
      end
   endtask

   task automatic test_indexed();
      wr_valid = 1'b1; wr_mode = 1'b1; wr_idx = 4'd5; wr_data = LW'(8'hAB);
      step();
      checks++;
      if (slot_of(5) !== LW'(8'hAB) || count !== 4'd6 || err !== 1'b0) begin
         errors++;
         $display("FAIL idx5: slot5=%0h count=%0d err=%b, required ab 6 0", slot_of(5), count, err);
      end
      wr_idx = 4'd2; wr_data = LW'(8'h12);
      step();
      checks++;
      if (slot_of(2) !== LW'(8'h12) || count !== 4'd6 || slot_of(5) !== LW'(8'hAB)) begin
         errors++;
         $display("FAIL idx2: slot2=%0h count=%0d slot5=%0h, required 12 6 ab",
                  slot_of(2), count, slot_of(5));
      end
      wr_idx = 4'd13; wr_data = LW'(8'h77);
      step();
      wr_valid = 1'b0;
      checks++;
      if (err !== 1'b1 || count !== 4'd6 || slot_of(0) !== '0) begin
         errors++;
         $display("FAIL idx13: err=%b count=%0d slot0=%0h, required 1 6 0", err, count, slot_of(0));
      end
      step();
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL idx13_err_width: err=%b, required 0", err);
      end
   endtask

   task automatic test_clr_restart();
      int n = 0;
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      for (int c = 0; c < 20 && busy; c++) begin
         n++;
         clr_req = (n == 6);
         step();
      end
      clr_req = 1'b0;
      checks++;
      if (n != 13 || busy !== 1'b0 || count !== 4'd0 || lines !== '0) begin
         errors++;
         $display("FAIL clr_restart: busy cycles=%0d busy=%b count=%0d, required 13 0 0", n, busy, count);
      end
   endtask

   task automatic test_reset_mid_clear();
      wr_valid = 1'b1; wr_mode = 1'b1; wr_idx = 4'd9; wr_data = LW'(8'h3C);
      step();
      wr_valid = 1'b0;
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      for (int c = 0; c < 3; c++) step();
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || lines !== '0 || count !== 4'd0 || wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_clear: busy=%b lines_zero=%b count=%0d rdy=%b, required 0 1 0 1",
                  busy, lines === '0, count, wr_ready);
      end
      step();
      wr_valid = 1'b1; wr_mode = 1'b0; wr_data = LW'(8'h55);
      rst_n = 1'b1;
      step();
      wr_valid = 1'b0;
      checks++;
      if (slot_of(0) !== LW'(8'h55) || count !== 4'd1) begin
         errors++;
         $display("FAIL first_write: slot0=%0h count=%0d, required 55 1", slot_of(0), count);
      end
   endtask

   task automatic test_back_to_back();
      int errs_seen = 0;
      do_reset();
      wr_valid = 1'b1; wr_mode = 1'b0; wr_data = LW'(8'hA1);
      step();
      if (err) errs_seen++;
      wr_valid = 1'b0; wr_data = LW'(8'hEE);
      for (int c = 0; c < 3; c++) begin
         step();
         if (err) errs_seen++;
      end
      wr_valid = 1'b1; wr_data = LW'(8'hB2);
      step();
      if (err) errs_seen++;
      wr_valid = 1'b0;
      step();
      if (err) errs_seen++;
      checks++;
      if (slot_of(0) !== LW'(8'hA1) || slot_of(1) !== LW'(8'hB2) || slot_of(2) !== '0 ||
          count !== 4'd2 || errs_seen != 0) begin
         errors++;
         $display("FAIL gap_append: s0=%0h s1=%0h s2=%0h count=%0d err_cycles=%0d, required a1 b2 0 2 0",
                  slot_of(0), slot_of(1), slot_of(2), count, errs_seen);
      end
   endtask

   initial begin
      test_reset();
      test_append_full();
      test_clear_with_write();
      test_indexed();
      test_clr_restart();
      test_reset_mid_clear();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sale_line_bank.md
SALE_LINE_BANK -- requirements
Module: sale_line_bank

Interface
REQ-001 Parameter NUM_LINES, default 13, number of stored display lines (slot index 0..12).
REQ-002 Parameter LINE_W, default 77, width of one display line.
REQ-003 The clock and reset ports SHALL be exactly: one clock, reset asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 wr_valid  input  1  write request present.
REQ-007 wr_ready  output  1  block can accept a write this cycle.
REQ-008 wr_mode  input  1  0 = append at next free slot, 1 = indexed write to wr_idx.
REQ-009 wr_idx  input  4  target slot for indexed write.
REQ-010 wr_data  input  LINE_W  line content.
REQ-011 clr_req  input  1  start clear sweep of all slots.
REQ-012 lines  output  NUM_LINES*LINE_W  flat bus; slot k on bits [k*LINE_W +: LINE_W]; feeds the 13:1 display selector.
REQ-013 count  output  4  number of valid lines (0..13).
REQ-014 full  output  1  count == 13.
REQ-015 empty  output  1  count == 0.
REQ-016 busy  output  1  clear sweep in progress.
REQ-017 err  output  1  one-cycle pulse on a rejected write.

Function
REQ-018 FSM states SHALL be IDLE and CLEAR only.
REQ-019 wr_ready SHALL equal (state == IDLE) && !clr_req, combinationally.
REQ-020 A write SHALL be accepted only on a cycle with wr_valid && wr_ready; its effects are visible on lines/count after that rising edge (latency 1).
REQ-021 Append (wr_mode=0), count < 13: slot[count] <= wr_data; count <= count+1.
REQ-022 Append with full=1: no slot or count change; err pulses high for the cycle after acceptance.
REQ-023 Indexed (wr_mode=1), wr_idx < 13: slot[wr_idx] <= wr_data; if wr_idx >= count then count <= wr_idx+1, else count unchanged.
REQ-024 Indexed with wr_idx >= 13: no state change; err pulses for one cycle.
REQ-025 err SHALL be registered, high exactly one cycle per rejected write, low otherwise.
REQ-026 clr_req high in IDLE: transition to CLEAR at next edge; any concurrent wr_valid is not accepted (wr_ready low).
REQ-027 CLEAR: internal 4-bit sweep pointer starts at 0; each cycle slot[ptr] <= 0 and ptr increments; after slot 12 is cleared, state returns to IDLE and count <= 0 on that same edge.
REQ-028 CLEAR SHALL last exactly 13 cycles; busy high for exactly those cycles; wr_ready low throughout.
REQ-029 clr_req asserted during CLEAR SHALL be ignored (no restart).
REQ-030 During CLEAR, count SHALL hold its pre-clear value until the final edge; lines shows partially cleared content.
REQ-031 Slots not written since reset/clear SHALL read all zeros.
REQ-032 full and empty SHALL be combinational decodes of count.
REQ-033 lines SHALL be driven directly from the slot registers, without an output pipeline stage.

Reset
REQ-034 rst_n low SHALL immediately force: all slots 0, count 0, state IDLE, sweep pointer 0, err 0, busy 0; hence empty 1, full 0, wr_ready = !clr_req.
REQ-035 rst_n asserted mid-CLEAR or coincident with a write SHALL abort the operation; no partial write survives.
REQ-036 The first write SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-037 Reset, then 13 appends of data k+1 -> slot k = k+1, count 13, full 1; 14th append -> err one cycle, slots and count unchanged.
REQ-038 Empty bank, indexed write idx=5 data 0xAB -> slot 5 = 0xAB, count 6; indexed idx=2 -> count stays 6; idx=13 -> err, no change.
REQ-039 Full bank, clr_req one cycle together with wr_valid -> write not accepted, busy high 13 cycles, all slots 0, count 0, wr_ready back high next cycle.
REQ-040 clr_req re-pulsed at sweep cycle 6 -> sweep still completes at cycle 13, no restart.
REQ-041 rst_n pulsed low at sweep cycle 4 -> all slots 0, IDLE, busy 0 immediately, without waiting for a clock edge.
REQ-042 Append, then wr_valid held low 3 cycles, then append -> exactly two slots written (0, 1), count 2, err never high.
